// File: rtl/prio_pkg.sv
// Shared types and widths for the aging priority queue.
// PRIO_W is fixed at 6 so that it matches the six_bit_adder datapath.
package prio_pkg;

    localparam int PRIO_W     = 6;
    localparam int TAG_W      = 4;
    localparam int SLOT_IDX_W = 3;
    localparam int OCC_W      = 4;

    localparam logic [PRIO_W-1:0] PRIO_MAX = 6'd63;

    typedef struct packed {
        logic              valid;
        logic [PRIO_W-1:0] prio;
        logic [TAG_W-1:0]  tag;
    } slot_t;

endpackage

// File: rtl/prio_sat_inc.sv
// Saturating priority increment: prio + AGE_STEP, clamped at PRIO_MAX.
// The adder carry out is used as the saturation flag.
module prio_sat_inc
    import prio_pkg::*;
#(
    parameter int AGE_STEP = 1
) (
    input  logic [PRIO_W-1:0] prio,
    output logic [PRIO_W-1:0] prio_next
);

    localparam logic [PRIO_W-1:0] STEP = PRIO_W'(AGE_STEP);

    logic [PRIO_W-1:0] sum;
    logic              carry;

    six_bit_adder u_add (
        .a     (prio),
        .b     (STEP),
        .c_in  (1'b0),
        .sum   (sum),
        .c_out (carry)
    );

    assign prio_next = carry ? PRIO_MAX : sum;

endmodule

// File: rtl/six_bit_adder.sv
// Six-bit ripple adder with carry in and carry out.
// This is the upstream datapath block that the queue reuses for aging.
module six_bit_adder (
    input  logic [5:0] a,
    input  logic [5:0] b,
    input  logic       c_in,
    output logic [5:0] sum,
    output logic       c_out
);

    assign {c_out, sum} = 7'(a) + 7'(b) + 7'(c_in);

endmodule

// File: rtl/prio_aging_queue.sv
// Small request queue that ages waiting entries and grants the highest priority.
// Ties go to the lowest slot index, and new entries become visible one cycle after enqueue.
module prio_aging_queue
    import prio_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int AGE_STEP = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [PRIO_W-1:0]     req_prio,
    input  logic [TAG_W-1:0]      req_tag,
    output logic                  gnt_valid,
    input  logic                  gnt_ready,
    output logic [PRIO_W-1:0]     gnt_prio,
    output logic [TAG_W-1:0]      gnt_tag,
    output logic [SLOT_IDX_W-1:0] gnt_slot,
    output logic [OCC_W-1:0]      occupancy
);

    slot_t             slots [NUM_REQ];
    logic [PRIO_W-1:0] aged  [NUM_REQ];

    logic                  sel_found;
    logic [SLOT_IDX_W-1:0] sel_idx;
    logic [PRIO_W-1:0]     sel_prio;
    logic [TAG_W-1:0]      sel_tag;
    logic                  free_found;
    logic [SLOT_IDX_W-1:0] free_idx;
    logic [OCC_W-1:0]      occ_cnt;
    logic                  enq;
    logic                  deq;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_age
        prio_sat_inc #(.AGE_STEP(AGE_STEP)) u_inc (
            .prio      (slots[g].prio),
            .prio_next (aged[g])
        );
    end

    // NOTE: every variable gets a default before the loop; a path that skips an
    // assignment in always_comb would otherwise infer a latch.
    always_comb begin
        sel_found  = 1'b0;
        sel_idx    = '0;
        sel_prio   = '0;
        sel_tag    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        occ_cnt    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (slots[i].valid) begin
                occ_cnt = occ_cnt + OCC_W'(1);
                // Strict '>' keeps the earlier (lower-index) slot on ties.
                if (!sel_found || (slots[i].prio > sel_prio)) begin
                    sel_found = 1'b1;
                    sel_idx   = SLOT_IDX_W'(i);
                    sel_prio  = slots[i].prio;
                    sel_tag   = slots[i].tag;
                end
            end else if (!free_found) begin
                free_found = 1'b1;
                free_idx   = SLOT_IDX_W'(i);
            end
        end
    end

    // req_ready depends on stored state only, never on gnt_ready.
    assign req_ready = (occ_cnt < OCC_W'(NUM_REQ));
    assign enq       = req_valid && req_ready && free_found;
    assign deq       = sel_found && gnt_ready;

    assign gnt_valid = sel_found;
    assign gnt_prio  = sel_prio;
    assign gnt_tag   = sel_tag;
    assign gnt_slot  = sel_idx;
    assign occupancy = occ_cnt;

    // NOTE: the slot array is cleared on reset, not just its valid bits, so that
    // prio/tag never carry stale or unknown values; state updates use <= only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                slots[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (enq && (free_idx == SLOT_IDX_W'(i))) begin
                    slots[i] <= '{valid: 1'b1, prio: req_prio, tag: req_tag};
                end else if (deq && (sel_idx == SLOT_IDX_W'(i))) begin
                    slots[i].valid <= 1'b0;
                end else if (slots[i].valid) begin
                    slots[i].prio <= aged[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_prio_aging_queue.sv
// Directed bench for prio_aging_queue: a per-cycle vector table plus hand-written
// sequences for reset, mid-operation reset and reuse of slot 0.
module tb_prio_aging_queue;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [5:0] req_prio;
    logic [3:0] req_tag;
    logic       gnt_valid;
    logic       gnt_ready;
    logic [5:0] gnt_prio;
    logic [3:0] gnt_tag;
    logic [2:0] gnt_slot;
    logic [3:0] occupancy;

    int checks = 0;
    int errors = 0;

    prio_aging_queue #(.NUM_REQ(4), .AGE_STEP(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_prio  (req_prio),
        .req_tag   (req_tag),
        .gnt_valid (gnt_valid),
        .gnt_ready (gnt_ready),
        .gnt_prio  (gnt_prio),
        .gnt_tag   (gnt_tag),
        .gnt_slot  (gnt_slot),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs applied for one cycle, with the outputs expected before that cycle's edge.
    typedef struct {
        logic       rv;
        logic [5:0] prio;
        logic [3:0] tag;
        logic       gr;
        logic       e_gv;
        logic [5:0] e_prio;
        logic [3:0] e_tag;
        logic [2:0] e_slot;
        logic [3:0] e_occ;
        logic       e_rr;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic gv, input logic [5:0] p,
                              input logic [3:0] t, input logic [2:0] s,
                              input logic [3:0] occ, input logic rr);
        check({tag, " gnt_valid"}, 32'(gnt_valid), 32'(gv));
        check({tag, " gnt_prio"},  32'(gnt_prio),  32'(p));
        check({tag, " gnt_tag"},   32'(gnt_tag),   32'(t));
        check({tag, " gnt_slot"},  32'(gnt_slot),  32'(s));
        check({tag, " occupancy"}, 32'(occupancy), 32'(occ));
        check({tag, " req_ready"}, 32'(req_ready), 32'(rr));
    endtask

    initial begin
        // Priority order: tags 1,2,3 at prio 10,40,20; grants tag2, tag3, tag1.
        vq.push_back('{1'b1, 6'd10, 4'd1,  1'b0, 1'b0, 6'd0,  4'd0, 3'd0, 4'd0, 1'b1});
        vq.push_back('{1'b1, 6'd40, 4'd2,  1'b0, 1'b1, 6'd10, 4'd1, 3'd0, 4'd1, 1'b1});
        vq.push_back('{1'b1, 6'd20, 4'd3,  1'b0, 1'b1, 6'd40, 4'd2, 3'd1, 4'd2, 1'b1});
        vq.push_back('{1'b0, 6'd0,  4'd0,  1'b1, 1'b1, 6'd41, 4'd2, 3'd1, 4'd3, 1'b1});
        vq.push_back('{1'b0, 6'd0,  4'd0,  1'b1, 1'b1, 6'd21, 4'd3, 3'd2, 4'd2, 1'b1});
        vq.push_back('{1'b0, 6'd0,  4'd0,  1'b1, 1'b1, 6'd14, 4'd1, 3'd0, 4'd1, 1'b1});
        vq.push_back('{1'b0, 6'd0,  4'd0,  1'b0, 1'b0, 6'd0,  4'd0, 3'd0, 4'd0, 1'b1});
        // Aging saturates at 63 with no wrap.
        vq.push_back('{1'b1, 6'd60, 4'd5,  1'b0, 1'b0, 6'd0,  4'd0, 3'd0, 4'd0, 1'b1});
        vq.push_back('{1'b0, 6'd0,  4'd0,  1'b0, 1'b1, 6'd60, 4'd5, 3'd0, 4'd1, 1'b1});
        vq.push_back('{1'b0, 6'd0,  4'd0,  1'b0, 1'b1, 6'd61, 4'd5, 3'd0, 4'd1, 1'b1});
        vq.push_back('{1'b0, 6'd0,  4'd0,  1'b0, 1'b1, 6'd62, 4'd5, 3'd0, 4'd1, 1'b1});
        vq.push_back('{1'b0, 6'd0,  4'd0,  1'b0, 1'b1, 6'd63, 4'd5, 3'd0, 4'd1, 1'b1});
        vq.push_back('{1'b0, 6'd0,  4'd0,  1'b0, 1'b1, 6'd63, 4'd5, 3'd0, 4'd1, 1'b1});
        vq.push_back('{1'b0, 6'd0,  4'd0,  1'b1, 1'b1, 6'd63, 4'd5, 3'd0, 4'd1, 1'b1});
        vq.push_back('{1'b0, 6'd0,  4'd0,  1'b0, 1'b0, 6'd0,  4'd0, 3'd0, 4'd0, 1'b1});
        // Tie-break: prio 5 in slot0 catches up with prio 6 in slot1; slot0 wins.
        vq.push_back('{1'b1, 6'd5,  4'd6,  1'b0, 1'b0, 6'd0,  4'd0, 3'd0, 4'd0, 1'b1});
        vq.push_back('{1'b1, 6'd6,  4'd7,  1'b0, 1'b1, 6'd5,  4'd6, 3'd0, 4'd1, 1'b1});
        vq.push_back('{1'b0, 6'd0,  4'd0,  1'b0, 1'b1, 6'd6,  4'd6, 3'd0, 4'd2, 1'b1});
        vq.push_back('{1'b0, 6'd0,  4'd0,  1'b1, 1'b1, 6'd7,  4'd6, 3'd0, 4'd2, 1'b1});
        vq.push_back('{1'b0, 6'd0,  4'd0,  1'b1, 1'b1, 6'd8,  4'd7, 3'd1, 4'd1, 1'b1});
        vq.push_back('{1'b0, 6'd0,  4'd0,  1'b0, 1'b0, 6'd0,  4'd0, 3'd0, 4'd0, 1'b1});
        // Fill, then full + gnt_ready: dequeue only; enqueue accepted next cycle.
        vq.push_back('{1'b1, 6'd1,  4'd1,  1'b0, 1'b0, 6'd0,  4'd0, 3'd0, 4'd0, 1'b1});
        vq.push_back('{1'b1, 6'd2,  4'd2,  1'b0, 1'b1, 6'd1,  4'd1, 3'd0, 4'd1, 1'b1});
        vq.push_back('{1'b1, 6'd3,  4'd3,  1'b0, 1'b1, 6'd2,  4'd1, 3'd0, 4'd2, 1'b1});
        vq.push_back('{1'b1, 6'd4,  4'd4,  1'b0, 1'b1, 6'd3,  4'd1, 3'd0, 4'd3, 1'b1});
        vq.push_back('{1'b1, 6'd9,  4'd9,  1'b1, 1'b1, 6'd4,  4'd1, 3'd0, 4'd4, 1'b0});
        // Simultaneous enqueue and dequeue at occupancy 3: occupancy stays 3, slot0 reused.
        vq.push_back('{1'b1, 6'd9,  4'd9,  1'b1, 1'b1, 6'd5,  4'd2, 3'd1, 4'd3, 1'b1});
        vq.push_back('{1'b1, 6'd0,  4'd10, 1'b0, 1'b1, 6'd9,  4'd9, 3'd0, 4'd3, 1'b1});
        // Full with gnt_ready low: the prio-50 request must be ignored.
        vq.push_back('{1'b1, 6'd50, 4'd12, 1'b0, 1'b1, 6'd10, 4'd9, 3'd0, 4'd4, 1'b0});
        vq.push_back('{1'b0, 6'd0,  4'd0,  1'b1, 1'b1, 6'd11, 4'd9, 3'd0, 4'd4, 1'b0});
        vq.push_back('{1'b0, 6'd0,  4'd0,  1'b0, 1'b1, 6'd9,  4'd3, 3'd2, 4'd3, 1'b1});

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_prio  = '0;
        req_tag   = '0;
        gnt_ready = 1'b0;

        // Reset held for two edges, then idle outputs.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_outs("reset", 1'b0, 6'd0, 4'd0, 3'd0, 4'd0, 1'b1);

        foreach (vq[k]) begin
            @(negedge clk);
            req_valid = vq[k].rv;
            req_prio  = vq[k].prio;
            req_tag   = vq[k].tag;
            gnt_ready = vq[k].gr;
            #1;
            check_outs($sformatf("vec%0d", k), vq[k].e_gv, vq[k].e_prio, vq[k].e_tag,
                       vq[k].e_slot, vq[k].e_occ, vq[k].e_rr);
        end

        // Mid-operation reset with three pending requests; the enqueue attempt is dropped.
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 1'b1;
        req_prio  = 6'd33;
        req_tag   = 4'd14;
        gnt_ready = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 1'b0;
        #1;
        check_outs("midreset", 1'b0, 6'd0, 4'd0, 3'd0, 4'd0, 1'b1);

        // Fresh enqueue lands in slot0 after the reset.
        @(negedge clk);
        req_valid = 1'b1;
        req_prio  = 6'd7;
        req_tag   = 4'd8;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check_outs("post_reset_enq", 1'b1, 6'd7, 4'd8, 3'd0, 4'd1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
